// File: rtl/ray_gen_scan.sv
// ray_gen_scan: raster-order primary-ray generator, one (origin, direction) pair per accepted transfer.
// Latency: first ray is valid one cycle after start; each following ray appears the cycle after a transfer (no bubbles).
// Backpressure: ray_vld/ray_rdy handshake; all ray outputs and flags hold while ray_vld && !ray_rdy.
// Optional build macro RAY_GEN_CONT_EN: continuous frames (FIN reloads and returns to RUN, one bubble per frame).
module ray_gen_scan #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] cam_x,
  input  logic [WIDTH-1:0] cam_y,
  input  logic [WIDTH-1:0] cam_z,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] focal,
  input  logic             ray_rdy,
  output logic             ray_vld,
  output logic [WIDTH-1:0] ax,
  output logic [WIDTH-1:0] ay,
  output logic [WIDTH-1:0] az,
  output logic [WIDTH-1:0] bx,
  output logic [WIDTH-1:0] by,
  output logic [WIDTH-1:0] bz,
  output logic [15:0]      pix_x,
  output logic [15:0]      pix_y,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             busy,
  output logic             done
);

  // FRAC only fixes how the coordinate bits are read; an impossible setting
  // leaves this named marker in the elaborated hierarchy.
  if (FRAC >= WIDTH) begin : g_frac_out_of_range
  end

  localparam logic [WIDTH-1:0] HALF_H = WIDTH'(H_RES >> 1);
  localparam logic [WIDTH-1:0] HALF_V = WIDTH'(V_RES >> 1);
  localparam logic [15:0]      LAST_X = 16'(H_RES - 1);
  localparam logic [15:0]      LAST_Y = 16'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_ax;
  logic [WIDTH-1:0] r_ay;
  logic [WIDTH-1:0] r_az;
  logic [WIDTH-1:0] r_bx;
  logic [WIDTH-1:0] r_by;
  logic [WIDTH-1:0] r_bz;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_bx0;
  logic [WIDTH-1:0] r_by0;
  logic [15:0]      r_pix_x;
  logic [15:0]      r_pix_y;
  logic             r_vld;

  logic [WIDTH-1:0] w_bx0;
  logic [WIDTH-1:0] w_by0;
  logic             w_load;
  logic             w_reload;
  logic             w_xfer;
  logic             w_last_x;
  logic             w_last_y;
  logic             w_done;
  logic             w_busy;

  // Row-start direction: leftmost column and top row of the image plane.
  // These constant-by-register products run only in the start cycle; the
  // per-pixel path is adders only. Results wrap to WIDTH bits.
  assign w_bx0 = -(HALF_H * step);
  assign w_by0 = HALF_V * step;

  assign w_load   = (r_state == S_IDLE) && start;
  assign w_xfer   = (r_state == S_RUN) && r_vld && ray_rdy;
  assign w_last_x = (r_pix_x == LAST_X);
  assign w_last_y = (r_pix_y == LAST_Y);

`ifdef RAY_GEN_CONT_EN
  assign w_reload = (r_state == S_FIN);
`else
  assign w_reload = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and status outputs; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_xfer && w_last_x && w_last_y) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_done = 1'b1;
`ifdef RAY_GEN_CONT_EN
        w_busy      = 1'b1;
        w_state_nxt = S_RUN;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame parameters: captured once per start, reused by continuous reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ax   <= '0;
      r_ay   <= '0;
      r_az   <= '0;
      r_bz   <= '0;
      r_step <= '0;
      r_bx0  <= '0;
      r_by0  <= '0;
    end else if (w_load) begin
      r_ax   <= cam_x;
      r_ay   <= cam_y;
      r_az   <= cam_z;
      r_bz   <= focal;
      r_step <= step;
      r_bx0  <= w_bx0;
      r_by0  <= w_by0;
    end
  end

  // Scan position and incremental direction; only advances on a transfer,
  // so a stalled ray stays exactly as presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bx    <= '0;
      r_by    <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_vld   <= 1'b0;
    end else if (w_load) begin
      r_bx    <= w_bx0;
      r_by    <= w_by0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_vld   <= 1'b1;
    end else if (w_reload) begin
      r_bx    <= r_bx0;
      r_by    <= r_by0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_vld   <= 1'b1;
    end else if (w_xfer) begin
      if (!w_last_x) begin
        r_pix_x <= r_pix_x + 16'd1;
        r_bx    <= r_bx + r_step;
      end else if (!w_last_y) begin
        r_pix_x <= '0;
        r_pix_y <= r_pix_y + 16'd1;
        r_bx    <= r_bx0;
        r_by    <= r_by - r_step;
      end else begin
        // Last pixel of the frame: position holds, valid drops with FIN.
        r_vld   <= 1'b0;
      end
    end
  end

  assign ray_vld = r_vld;
  assign ax      = r_ax;
  assign ay      = r_ay;
  assign az      = r_az;
  assign bx      = r_bx;
  assign by      = r_by;
  assign bz      = r_bz;
  assign pix_x   = r_pix_x;
  assign pix_y   = r_pix_y;
  // Flags only mean something alongside a valid ray.
  assign sof     = r_vld && (r_pix_x == 16'd0) && (r_pix_y == 16'd0);
  assign eol     = r_vld && w_last_x;
  assign eof     = r_vld && w_last_x && w_last_y;
  assign busy    = w_busy;
  assign done    = w_done;

endmodule

// File: tb/tb_ray_gen_scan.sv
// Bench for ray_gen_scan at H_RES=4, V_RES=2 with a pixel-indexed reference model.
// Checks reset, fixed example vectors, stalls, ignored start, mid-frame reset, random frames.
// Build with RAY_GEN_CONT_EN defined to exercise continuous frames instead.
module tb_ray_gen_scan;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int OW   = 1 + 6 * 32 + 32 + 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cam_x, cam_y, cam_z, step, focal;
  logic        ray_rdy;
  logic        ray_vld;
  logic [31:0] ax, ay, az, bx, by, bz;
  logic [15:0] pix_x, pix_y;
  logic        sof, eol, eof, busy, done;

  int total = 0;
  int bad   = 0;

  // Values the model believes were latched at the last start.
  logic [31:0] m_cx, m_cy, m_cz, m_step, m_focal;

  ray_gen_scan #(.WIDTH(32), .FRAC(16), .H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z), .step(step), .focal(focal),
    .ray_rdy(ray_rdy), .ray_vld(ray_vld),
    .ax(ax), .ay(ay), .az(az), .bx(bx), .by(by), .bz(bz),
    .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] all_outs();
    return {ray_vld, ax, ay, az, bx, by, bz, pix_x, pix_y, sof, eol, eof, busy, done};
  endfunction

  // Expected outputs for pixel number k: direction is the pixel's offset
  // from the image centre times the pitch, wrapped to 32 bits.
  function automatic logic [OW-1:0] model_ray(int k);
    int x, y;
    logic [31:0] ebx, eby;
    x   = k % H;
    y   = k / H;
    ebx = 32'(x - H / 2) * m_step;
    eby = 32'(V / 2 - y) * m_step;
    return {1'b1, m_cx, m_cy, m_cz, ebx, eby, m_focal, 16'(x), 16'(y),
            (k == 0), (x == H - 1), (k == NPIX - 1), 1'b1, 1'b0};
  endfunction

  // Called at a negedge; leaves at the negedge where the first ray is shown.
  task automatic pulse_start(input logic [31:0] cx, cy, cz, st, fc);
    m_cx = cx; m_cy = cy; m_cz = cz; m_step = st; m_focal = fc;
    cam_x = cx; cam_y = cy; cam_z = cz; step = st; focal = fc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cam_x = $urandom(); cam_y = $urandom(); cam_z = $urandom();
    step  = $urandom(); focal = $urandom();
  endtask

  // One frame from the currently shown first ray through the FIN cycle.
  task automatic frame_scenario(input string nm, input int rdy_pct, input int stall_idx,
                                input int stall_len, input bit poke, output int cycles);
    int k = 0;
    int stalled = 0;
    bit poked = 0;
    logic [OW-1:0] got, exp;
    cycles = 0;
    while (k < NPIX && cycles < 500) begin
      got = all_outs();
      exp = model_ray(k);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s ray%0d got=%h exp=%h", nm, k, got, exp);
      end
      if (k == stall_idx && stalled < stall_len) begin
        ray_rdy = 1'b0;
        stalled++;
      end else begin
        ray_rdy = ($urandom_range(99) < rdy_pct) ? 1'b1 : 1'b0;
      end
      if (poke && k == 3 && !poked) begin
        start = 1'b1;
        cam_x = ~m_cx;
        poked = 1;
      end else begin
        start = 1'b0;
      end
      if (ray_rdy) k++;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    total++;
    if (k != NPIX) begin
      bad++;
      $display("FAIL %s timeout got=%0d rays exp=%0d", nm, k, NPIX);
    end
    // FIN cycle.
    total++;
`ifdef RAY_GEN_CONT_EN
    if ({ray_vld, busy, done} !== 3'b011) begin
`else
    if ({ray_vld, busy, done} !== 3'b001) begin
`endif
      bad++;
      $display("FAIL %s fin vld/busy/done got=%b", nm, {ray_vld, busy, done});
    end
    @(negedge clk);
    total++;
`ifdef RAY_GEN_CONT_EN
    if ({ray_vld, busy, done, sof} !== 4'b1101) begin
`else
    if ({ray_vld, busy, done, sof} !== 4'b0000) begin
`endif
      bad++;
      $display("FAIL %s after_fin vld/busy/done/sof got=%b", nm, {ray_vld, busy, done, sof});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ray_rdy = 1'b1;
    cam_x = '0; cam_y = '0; cam_z = '0; step = '0; focal = '0;
    repeat (2) @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%h exp=0", all_outs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL idle_outs got=%h exp=0", all_outs());
    end
  endtask

  task automatic test_spec_example();
    int cyc;
    pulse_start(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000);
    total++;
    if ({ax, bx, by, bz, sof} !== {32'h0001_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0002_0000, 1'b1}) begin
      bad++;
      $display("FAIL first_ray got ax=%h bx=%h by=%h bz=%h sof=%b", ax, bx, by, bz, sof);
    end
    frame_scenario("example", 100, -1, 0, 0, cyc);
    total++;
    if (cyc != NPIX) begin
      bad++;
      $display("FAIL example_cycles got=%0d exp=%0d", cyc, NPIX);
    end
  endtask

  task automatic test_stall();
    int cyc;
    pulse_start(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000);
    frame_scenario("stall", 100, 2, 5, 0, cyc);
    total++;
    if (cyc != NPIX + 5) begin
      bad++;
      $display("FAIL stall_cycles got=%0d exp=%0d", cyc, NPIX + 5);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    pulse_start(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000);
    frame_scenario("start_ignored", 100, -1, 0, 1, cyc);
  endtask

  task automatic test_reset_midframe();
    int cyc;
    pulse_start($urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    ray_rdy = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({pix_x, pix_y} !== {16'd1, 16'd1}) begin
      bad++;
      $display("FAIL midframe_pos got=(%0d,%0d) exp=(1,1)", pix_x, pix_y);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL midframe_reset got=%h exp=0", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start($urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    frame_scenario("after_reset", 100, -1, 0, 0, cyc);
  endtask

  task automatic test_random();
    int cyc;
    for (int i = 0; i < 4; i++) begin
      pulse_start($urandom(), $urandom(), $urandom(), $urandom(), $urandom());
      frame_scenario("random", 50, -1, 0, (i == 1), cyc);
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    int cyc;
    pulse_start(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000);
    for (int f = 0; f < 3; f++) begin
      frame_scenario("cont", 100, -1, 0, (f == 1), cyc);
      total++;
      if (cyc != NPIX) begin
        bad++;
        $display("FAIL cont_period got=%0d exp=%0d", cyc + 1, NPIX + 1);
      end
    end
    frame_scenario("cont_rand", 50, -1, 0, 0, cyc);
  endtask

  initial begin
    test_reset();
`ifdef RAY_GEN_CONT_EN
    test_continuous();
`else
    test_spec_example();
    test_stall();
    test_start_ignored();
    test_reset_midframe();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
